// File: rtl/dly_seq_pkg.sv
// Shared types for the sequenced delay line.
//   dly_seq_state_t : session FSM state (IDLE -> FILL -> RUN -> FLUSH -> IDLE)
package dly_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } dly_seq_state_t;

endpackage

// File: rtl/en_delay_line.sv
// Enable-gated delay line: LEN words of data plus a valid bit per word.
// The whole line advances by one stage on every cycle with shift_en high.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   shift_en       : advance the line this edge
//   d_in, d_in_val : word/valid loaded into stage 0 on an advance
//   d_out          : last-stage data (combinational view of the register)
//   d_out_val_raw  : last-stage valid bit, not gated by any session state
module en_delay_line
    import dly_seq_pkg::*;
#(
    parameter int LEN = 8,
    parameter int DW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic signed [DW-1:0] d_in,
    input  logic                 d_in_val,
    output logic signed [DW-1:0] d_out,
    output logic                 d_out_val_raw
);

    logic [LEN-1:0][DW-1:0] r_data;
    logic [LEN-1:0]         r_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_val  <= '0;
        end else if (shift_en) begin
            r_data <= {r_data[LEN-2:0], d_in};
            r_val  <= {r_val[LEN-2:0], d_in_val};
        end
    end

    assign d_out         = r_data[LEN-1];
    assign d_out_val_raw = r_val[LEN-1];

endmodule

// File: rtl/dly_line_seq.sv
// Session-controlled delay line. A start pulse opens a session that fills
// the line at a programmable shift rate, runs it once full, and on stop
// drains the remaining valid words before returning to idle.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (wins over all)
//   start, stop       : session control pulses
//   rate              : shift period minus one, captured on an accepted start
//   d_in, d_in_val    : input sample and qualifier (used on tick cycles only)
//   shift_en          : one-cycle strobe, the cycle after each line advance
//   d_out, d_out_val  : delayed sample and its one-cycle qualifier
//   busy, primed      : not idle / in RUN
//   fill_cnt          : number of valid words currently in the line
//   ovf_cnt           : dropped-sample counter, present only when
//                       DLY_LINE_SEQ_OVF_CNT_EN is defined
module dly_line_seq
    import dly_seq_pkg::*;
#(
    parameter int LEN    = 8,
    parameter int DW     = 16,
    parameter int RATE_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic [RATE_W-1:0]          rate,
    input  logic signed [DW-1:0]       d_in,
    input  logic                       d_in_val,
    output logic                       shift_en,
    output logic signed [DW-1:0]       d_out,
    output logic                       d_out_val,
    output logic                       busy,
    output logic                       primed,
`ifdef DLY_LINE_SEQ_OVF_CNT_EN
    output logic [15:0]                ovf_cnt,
`endif
    output logic [$clog2(LEN+1)-1:0]   fill_cnt
);

    localparam int CW = $clog2(LEN+1);

    dly_seq_state_t        r_state;
    logic [RATE_W-1:0]     r_div_cnt;
    logic [RATE_W-1:0]     r_rate_q;
    logic [CW-1:0]         r_fill_cnt;
    logic                  r_shift_en;
    logic signed [DW-1:0]  r_d_out;
    logic                  r_d_out_val;

    logic                  w_tick;
    logic                  w_loading;
    logic signed [DW-1:0]  w_in_data;
    logic                  w_in_val;
    logic signed [DW-1:0]  w_line_data;
    logic                  w_line_val;
    logic [CW-1:0]         w_fill_nxt;

    assign w_tick    = (r_state != S_IDLE) && (r_div_cnt == r_rate_q);
    // FLUSH feeds zeros with val 0 so the line empties behind the last word
    assign w_loading = (r_state == S_FILL) || (r_state == S_RUN);
    assign w_in_data = w_loading ? d_in : '0;
    assign w_in_val  = w_loading && d_in_val;

    en_delay_line #(
        .LEN (LEN),
        .DW  (DW)
    ) u_line (
        .clk           (clk),
        .rst           (rst),
        .shift_en      (w_tick),
        .d_in          (w_in_data),
        .d_in_val      (w_in_val),
        .d_out         (w_line_data),
        .d_out_val_raw (w_line_val)
    );

    // Occupancy after this edge: +1 per valid word in, -1 per valid word out.
    // A word leaving during FILL is still counted out even though it is not
    // emitted, so fill_cnt always matches what the line really holds.
    always_comb begin
        w_fill_nxt = r_fill_cnt;
        if (w_tick) begin
            case ({w_in_val, w_line_val})
                2'b10:   if (r_fill_cnt != CW'(LEN)) w_fill_nxt = r_fill_cnt + CW'(1);
                2'b01:   if (r_fill_cnt != '0)       w_fill_nxt = r_fill_cnt - CW'(1);
                default: w_fill_nxt = r_fill_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_div_cnt   <= '0;
            r_rate_q    <= '0;
            r_fill_cnt  <= '0;
            r_shift_en  <= 1'b0;
            r_d_out     <= '0;
            r_d_out_val <= 1'b0;
        end else begin
            r_shift_en  <= w_tick;
            r_d_out_val <= 1'b0;
            if (w_tick && ((r_state == S_RUN) || (r_state == S_FLUSH))) begin
                r_d_out     <= w_line_data;
                r_d_out_val <= w_line_val;
            end

            if (r_state != S_IDLE) begin
                r_div_cnt  <= w_tick ? '0 : r_div_cnt + RATE_W'(1);
                r_fill_cnt <= w_fill_nxt;
            end

            case (r_state)
                S_IDLE: begin
                    r_div_cnt <= '0;
                    // start together with stop cancels itself
                    if (start && !stop) begin
                        r_state    <= S_FILL;
                        r_rate_q   <= rate;
                        r_fill_cnt <= '0;
                    end
                end
                S_FILL: begin
                    if (stop)
                        r_state <= S_FLUSH;
                    else if (w_tick && (w_fill_nxt == CW'(LEN)))
                        r_state <= S_RUN;
                end
                S_RUN: begin
                    if (stop) r_state <= S_FLUSH;
                end
                S_FLUSH: begin
                    // empty on entry, or the last valid word just left
                    if ((r_fill_cnt == '0) || (w_tick && (w_fill_nxt == '0))) begin
                        r_state   <= S_IDLE;
                        r_div_cnt <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DLY_LINE_SEQ_OVF_CNT_EN
    logic [15:0] r_ovf_cnt;

    // counts samples offered between ticks, which the line never sees
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_cnt <= '0;
        end else if ((r_state == S_IDLE) && start && !stop) begin
            r_ovf_cnt <= '0;
        end else if (w_loading && d_in_val && !w_tick && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

    assign shift_en  = r_shift_en;
    assign d_out     = r_d_out;
    assign d_out_val = r_d_out_val;
    assign fill_cnt  = r_fill_cnt;
    assign busy      = (r_state != S_IDLE);
    assign primed    = (r_state == S_RUN);

endmodule

// File: tb/tb_dly_line_seq.sv
// Directed bench for dly_line_seq with LEN=4.
module tb_dly_line_seq;

    localparam int LEN    = 4;
    localparam int DW     = 16;
    localparam int RATE_W = 8;
    localparam int CW     = $clog2(LEN+1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 stop;
    logic [RATE_W-1:0]    rate;
    logic signed [DW-1:0] d_in;
    logic                 d_in_val;
    logic                 shift_en;
    logic signed [DW-1:0] d_out;
    logic                 d_out_val;
    logic                 busy;
    logic                 primed;
    logic [CW-1:0]        fill_cnt;
`ifdef DLY_LINE_SEQ_OVF_CNT_EN
    logic [15:0]          ovf_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;
    int pulses;

    always #5 clk = ~clk;

    dly_line_seq #(.LEN(LEN), .DW(DW), .RATE_W(RATE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .rate      (rate),
        .d_in      (d_in),
        .d_in_val  (d_in_val),
        .shift_en  (shift_en),
        .d_out     (d_out),
        .d_out_val (d_out_val),
        .busy      (busy),
        .primed    (primed),
`ifdef DLY_LINE_SEQ_OVF_CNT_EN
        .ovf_cnt   (ovf_cnt),
`endif
        .fill_cnt  (fill_cnt)
    );

    task automatic clk1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; rate = '0; d_in = '0; d_in_val = 1'b0;
        clk1; clk1;
        chk("rst_busy", busy, 0);
        chk("rst_primed", primed, 0);
        chk("rst_fill", fill_cnt, 0);
        chk("rst_shift_en", shift_en, 0);
        chk("rst_dout", $unsigned(d_out), 0);
        chk("rst_dout_val", d_out_val, 0);
`ifdef DLY_LINE_SEQ_OVF_CNT_EN
        chk("rst_ovf", ovf_cnt, 0);
`endif
        rst = 1'b0;

        // rate 0: fill with 1..4, then 4-tick latency
        start = 1'b1; rate = 8'd0; clk1; start = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_fill0", fill_cnt, 0);
        chk("t1_shift0", shift_en, 0);
        for (int n = 1; n <= 4; n++) begin
            d_in = DW'(n); d_in_val = 1'b1; clk1;
            chk("t1_fill", fill_cnt, n);
            chk("t1_shift", shift_en, 1);
            chk("t1_dov_fill", d_out_val, 0);
            chk("t1_primed", primed, (n == 4) ? 1 : 0);
        end
        for (int n = 5; n <= 10; n++) begin
            d_in = DW'(n); clk1;
            chk("t1_dov", d_out_val, 1);
            chk("t1_dout", $unsigned(d_out), n - 4);
            chk("t1_fill_run", fill_cnt, 4);
        end

        // stop in RUN with 7,8,9,10 held: four pulses then idle
        stop = 1'b1; d_in = '0; d_in_val = 1'b0; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            clk1; stop = 1'b0;
            if (d_out_val) begin
                chk("t3_flush_data", $unsigned(d_out), 7 + pulses);
                pulses++;
            end
        end
        chk("t3_pulses", pulses, 4);
        chk("t3_busy", busy, 0);
        chk("t3_fill", fill_cnt, 0);
        chk("t3_primed", primed, 0);

        // stop in FILL after two valid words
        start = 1'b1; clk1; start = 1'b0;
        d_in = 16'sd31; d_in_val = 1'b1; clk1;
        d_in = 16'sd32; clk1;
        chk("t4_fill", fill_cnt, 2);
        stop = 1'b1; d_in_val = 1'b0; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            clk1; stop = 1'b0;
            if (d_out_val) begin
                chk("t4_flush_data", $unsigned(d_out), 31 + pulses);
                pulses++;
            end
        end
        chk("t4_pulses", pulses, 2);
        chk("t4_busy", busy, 0);

        // stop with an empty line: FLUSH for one cycle only
        start = 1'b1; clk1; start = 1'b0;
        stop = 1'b1; clk1; stop = 1'b0;
        chk("t4z_busy_flush", busy, 1);
        chk("t4z_fill", fill_cnt, 0);
        clk1;
        chk("t4z_idle", busy, 0);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1; clk1; start = 1'b0; stop = 1'b0;
        chk("t5_busy", busy, 0);
        clk1;
        chk("t5_busy2", busy, 0);
        chk("t5_shift", shift_en, 0);

        // rate 2: tick every third cycle, off-tick samples dropped,
        // start during RUN ignored (period must stay 3)
        start = 1'b1; rate = 8'd2; clk1; start = 1'b0; rate = 8'd0;
        chk("t2_busy", busy, 1);
        for (int i = 0; i < 18; i++) begin
            d_in = DW'(100 + i); d_in_val = 1'b1;
            if (i == 12) begin start = 1'b1; rate = 8'd0; end
            else start = 1'b0;
            clk1;
            chk("t2_shift", shift_en, (i % 3 == 2) ? 1 : 0);
            chk("t2_dov", d_out_val, (i == 14 || i == 17) ? 1 : 0);
            if (i == 14) chk("t2_dout14", $unsigned(d_out), 102);
            if (i == 17) chk("t2_dout17", $unsigned(d_out), 105);
            if (i == 11) begin
                chk("t2_fill", fill_cnt, 4);
                chk("t2_primed", primed, 1);
`ifdef DLY_LINE_SEQ_OVF_CNT_EN
                chk("t2_ovf_fill", ovf_cnt, 8);
`endif
            end
        end
        start = 1'b0;
        chk("t2_still_run", primed, 1);
`ifdef DLY_LINE_SEQ_OVF_CNT_EN
        chk("t2_ovf_run", ovf_cnt, 12);
`endif

        // reset on a tick edge mid-RUN
        clk1; clk1;
        rst = 1'b1; clk1;
        chk("t6_busy", busy, 0);
        chk("t6_primed", primed, 0);
        chk("t6_fill", fill_cnt, 0);
        chk("t6_shift", shift_en, 0);
        chk("t6_dout", $unsigned(d_out), 0);
        chk("t6_dov", d_out_val, 0);
`ifdef DLY_LINE_SEQ_OVF_CNT_EN
        chk("t6_ovf", ovf_cnt, 0);
`endif
        rst = 1'b0; d_in_val = 1'b0; clk1;
        chk("t6_dov2", d_out_val, 0);
        chk("t6_idle", busy, 0);

        // refill from empty after reset
        start = 1'b1; rate = 8'd0; clk1; start = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            d_in = DW'(200 + n); d_in_val = 1'b1; clk1;
            chk("t7_fill", fill_cnt, n);
            chk("t7_dov", d_out_val, 0);
        end
        chk("t7_primed", primed, 1);
        d_in = 16'sd205; clk1;
        chk("t7_dov_first", d_out_val, 1);
        chk("t7_dout_first", $unsigned(d_out), 201);
        d_in_val = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
